// File: rtl/demux8bit_stream.sv
// demux8bit_stream: registered 1:2 stream demultiplexer.
// Each input beat carries a select bit and is steered into one of two
// per-channel FIFOs. Because each channel buffers independently, a stalled
// sink only blocks the input when the current beat targets its full FIFO.
// Each channel keeps a wrapping count of delivered beats for downstream
// error/approximation bookkeeping.
module demux8bit_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y0_data,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic [WIDTH-1:0] y1_data,
  output logic [CNT_W-1:0] y0_cnt,
  output logic [CNT_W-1:0] y1_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  // Pointer advance; DEPTH is a power of two so natural overflow wraps to 0.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return p + PW'(1);
  endfunction

  logic [WIDTH-1:0] mem_r    [2][DEPTH];
  logic [PW-1:0]    wr_ptr_r [2];
  logic [PW-1:0]    rd_ptr_r [2];
  logic [OW-1:0]    occ_r    [2];
  logic [CNT_W-1:0] cnt_r    [2];

  logic [1:0] full_s;
  logic [1:0] valid_s;
  logic [1:0] push_s;
  logic [1:0] pop_s;
  logic [1:0] out_ready_s;
  logic       in_ready_s;

  // Per-channel status and handshake decode; ready depends only on in_sel and occupancy.
  always_comb begin
    full_s      = 2'b00;
    valid_s     = 2'b00;
    push_s      = 2'b00;
    pop_s       = 2'b00;
    out_ready_s = {y1_ready, y0_ready};
    for (int k = 0; k < 2; k++) begin
      full_s[k]  = (occ_r[k] == OCC_FULL);
      valid_s[k] = (occ_r[k] != {OW{1'b0}});
    end
    in_ready_s = ~full_s[in_sel];
    for (int k = 0; k < 2; k++) begin
      push_s[k] = in_valid & in_ready_s & (in_sel == 1'(k));
      pop_s[k]  = valid_s[k] & out_ready_s[k];
    end
  end

  assign in_ready = in_ready_s;
  assign y0_valid = valid_s[0];
  assign y1_valid = valid_s[1];
  assign y0_data  = mem_r[0][rd_ptr_r[0]];
  assign y1_data  = mem_r[1][rd_ptr_r[1]];
  assign y0_cnt   = cnt_r[0];
  assign y1_cnt   = cnt_r[1];

  // FIFO storage, pointers, occupancy and delivered-beat counters for both channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int e = 0; e < DEPTH; e++) begin
          mem_r[k][e] <= {WIDTH{1'b0}};
        end
        wr_ptr_r[k] <= {PW{1'b0}};
        rd_ptr_r[k] <= {PW{1'b0}};
        occ_r[k]    <= {OW{1'b0}};
        cnt_r[k]    <= {CNT_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push_s[k]) begin
          mem_r[k][wr_ptr_r[k]] <= in_data;
          wr_ptr_r[k]           <= ptr_inc(wr_ptr_r[k]);
        end
        if (pop_s[k]) begin
          rd_ptr_r[k] <= ptr_inc(rd_ptr_r[k]);
          cnt_r[k]    <= cnt_r[k] + CNT_W'(1);
        end
        case ({push_s[k], pop_s[k]})
          2'b10:   occ_r[k] <= occ_r[k] + OW'(1);
          2'b01:   occ_r[k] <= occ_r[k] - OW'(1);
          default: occ_r[k] <= occ_r[k];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_demux8bit_stream.sv
// Scoreboard bench for demux8bit_stream: stimulus pushes expected beats into
// per-channel queues; a monitor pops and compares on every output handshake
// and tracks the expected delivered-beat counters.
module tb_demux8bit_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_sel;
  logic [7:0] in_data;
  logic       y0_valid, y0_ready;
  logic [7:0] y0_data;
  logic       y1_valid, y1_ready;
  logic [7:0] y1_data;
  logic [7:0] y0_cnt, y1_cnt;

  int chk_cnt  = 0;
  int fail_cnt = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] ec0 = 8'd0;
  logic [7:0] ec1 = 8'd0;

  demux8bit_stream #(.WIDTH(8), .DEPTH(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .y0_valid(y0_valid), .y0_ready(y0_ready), .y0_data(y0_data),
    .y1_valid(y1_valid), .y1_ready(y1_ready), .y1_data(y1_data),
    .y0_cnt(y0_cnt), .y1_cnt(y1_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one beat (called at posedge+1); waits for in_ready with a bounded budget.
  task automatic push(input logic sel, input logic [7:0] d);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        if (sel) q1.push_back(d); else q0.push_back(d);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      fail_cnt++;
      chk_cnt++;
      $display("FAIL push_timeout: sel %0d data 0x%0h never accepted", sel, d);
    end
    in_valid = 1'b0;
  endtask

  // Monitor: compares counters and handshaken output data against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      ec0 = 8'd0;
      ec1 = 8'd0;
    end else begin
      check("y0_cnt", {24'd0, y0_cnt}, {24'd0, ec0});
      check("y1_cnt", {24'd0, y1_cnt}, {24'd0, ec1});
      if (y0_valid && y0_ready) begin
        if (q0.size() == 0) begin
          chk_cnt++;
          fail_cnt++;
          $display("FAIL y0_unexpected: got 0x%0h expected no beat", y0_data);
        end else begin
          check("y0_data", {24'd0, y0_data}, {24'd0, q0.pop_front()});
        end
        ec0 = ec0 + 8'd1;
      end
      if (y1_valid && y1_ready) begin
        if (q1.size() == 0) begin
          chk_cnt++;
          fail_cnt++;
          $display("FAIL y1_unexpected: got 0x%0h expected no beat", y1_data);
        end else begin
          check("y1_data", {24'd0, y1_data}, {24'd0, q1.pop_front()});
        end
        ec1 = ec1 + 8'd1;
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_data  = 8'h00;
    y0_ready = 1'b0;
    y1_ready = 1'b0;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_y0_valid", {31'd0, y0_valid}, 32'd0);
    check("rst_y1_valid", {31'd0, y1_valid}, 32'd0);
    check("rst_y0_data", {24'd0, y0_data}, 32'h00);
    check("rst_y1_data", {24'd0, y1_data}, 32'h00);
    check("rst_y0_cnt", {24'd0, y0_cnt}, 32'd0);
    check("rst_y1_cnt", {24'd0, y1_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic steering with both sinks ready; one-cycle latency.
    y0_ready = 1'b1;
    y1_ready = 1'b1;
    push(1'b0, 8'hA5);
    check("lat_y0_valid", {31'd0, y0_valid}, 32'd1);
    check("lat_y0_data", {24'd0, y0_data}, 32'hA5);
    push(1'b1, 8'h3C);
    check("lat_y1_valid", {31'd0, y1_valid}, 32'd1);
    check("lat_y1_data", {24'd0, y1_data}, 32'h3C);
    repeat (2) @(posedge clk);
    #1;
    check("basic_y0_cnt", {24'd0, y0_cnt}, 32'd1);
    check("basic_y1_cnt", {24'd0, y1_cnt}, 32'd1);

    // Fill channel 0, stall on it, bypass to channel 1, then drain.
    y0_ready = 1'b0;
    push(1'b0, 8'h11);
    push(1'b0, 8'h22);
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 8'h33;
    #1;
    check("full_ready_sel0", {31'd0, in_ready}, 32'd0);
    in_sel  = 1'b1;
    in_data = 8'h44;
    #1;
    check("full_ready_sel1", {31'd0, in_ready}, 32'd1);
    push(1'b1, 8'h44);
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 8'h33;
    y0_ready = 1'b1;
    @(negedge clk);
    check("stall_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("after_pop_ready", {31'd0, in_ready}, 32'd1);
    check("after_pop_head", {24'd0, y0_data}, 32'h22);
    q0.push_back(8'h33);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("late_y0_valid", {31'd0, y0_valid}, 32'd1);
    check("late_y0_head", {24'd0, y0_data}, 32'h33);
    repeat (2) @(posedge clk);
    #1;

    // Same-cycle push and pop on channel 1 at occupancy 1.
    y1_ready = 1'b0;
    push(1'b1, 8'h66);
    check("pp_head_66", {24'd0, y1_data}, 32'h66);
    y1_ready = 1'b1;
    push(1'b1, 8'h55);
    check("pp_valid", {31'd0, y1_valid}, 32'd1);
    check("pp_head_55", {24'd0, y1_data}, 32'h55);
    @(posedge clk);
    #1;
    check("pp_empty", {31'd0, y1_valid}, 32'd0);

    // Counter wrap: 4 beats already on channel 0, 252 more reach 256.
    for (int i = 0; i < 252; i++) begin
      push(1'b0, 8'(i));
    end
    repeat (3) @(posedge clk);
    #1;
    check("wrap_y0_cnt", {24'd0, y0_cnt}, 32'h00);
    check("wrap_y1_cnt", {24'd0, y1_cnt}, 32'd4);

    // Asynchronous reset with data buffered in both FIFOs.
    y0_ready = 1'b0;
    y1_ready = 1'b0;
    push(1'b0, 8'h77);
    push(1'b1, 8'h88);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_y0_valid", {31'd0, y0_valid}, 32'd0);
    check("arst_y1_valid", {31'd0, y1_valid}, 32'd0);
    check("arst_y0_data", {24'd0, y0_data}, 32'h00);
    check("arst_y1_data", {24'd0, y1_data}, 32'h00);
    check("arst_y0_cnt", {24'd0, y0_cnt}, 32'd0);
    check("arst_y1_cnt", {24'd0, y1_cnt}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    y0_ready = 1'b1;
    y1_ready = 1'b1;
    push(1'b0, 8'h99);

    // Drain with a bounded wait.
    for (int t = 0; t < 100 && (q0.size() != 0 || q1.size() != 0); t++) begin
      @(posedge clk);
    end
    #1;
    check("drain_q0", q0.size(), 32'd0);
    check("drain_q1", q1.size(), 32'd0);
    check("post_rst_y0_cnt", {24'd0, y0_cnt}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/demux8bit_stream.md
Name: demux8bit_stream

Overview:
- Registered 1:2 demultiplexer: the inverse of the 8-bit 2:1 select path in the comparator datapath.
- Takes one valid/ready input stream with a per-beat select bit and steers each beat to output channel 0 or 1.
- Each channel has its own small FIFO, so a stalled channel does not block beats bound for the other channel (except when the stalled channel's FIFO is full and the current beat targets it).
- Per-channel wrapping transfer counters support approximation/error bookkeeping downstream.

Parameters:
- WIDTH, 8, data width of each beat.
- DEPTH, 2, entries per channel FIFO. Must be a power of 2 and at least 2.
- CNT_W, 8, width of each per-channel delivered-beat counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept the beat on in_sel.
- in_sel  input  1  destination channel; 0 selects y0, 1 selects y1.
- in_data  input  WIDTH  input beat data.
- y0_valid  output  1  channel 0 FIFO non-empty.
- y0_ready  input  1  channel 0 sink accepts.
- y0_data  output  WIDTH  channel 0 head entry.
- y1_valid  output  1  channel 1 FIFO non-empty.
- y1_ready  input  1  channel 1 sink accepts.
- y1_data  output  WIDTH  channel 1 head entry.
- y0_cnt  output  CNT_W  count of beats delivered on channel 0.
- y1_cnt  output  CNT_W  count of beats delivered on channel 1.

Behaviour:
- Clock and reset: one clock domain. rst_n low asynchronously clears both FIFOs (pointers and occupancy to 0, storage to 0) and both counters. Reset values: in_ready=1, y0_valid=y1_valid=0, y0_data=y1_data=0, y0_cnt=y1_cnt=0. Asserting reset mid-transfer discards all buffered beats; no partial state survives.
- in_ready = NOT full[in_sel]. This is combinational from in_sel and the occupancy registers only. It never depends on in_valid or on either y*_ready, so there is no combinational ready-through path.
- Input accept: occurs when in_valid && in_ready at a rising edge. in_data is written at the write pointer of FIFO[in_sel], and that write pointer and occupancy advance.
- Latency: a beat accepted at edge N into an empty FIFO gives y*_valid=1 with that data immediately after edge N (one cycle).
- Output: yK_valid = (occK != 0). yK_data = storage[rd_ptrK]. yK_valid drops only after the beat is consumed. yK_data is stable while yK_valid=1 and yK_ready=0.
- Output consume: occurs when yK_valid && yK_ready. The read pointer advances and occupancy decrements.
- Same-cycle push and pop on one channel: if the FIFO is neither full nor empty, both happen and occupancy is unchanged. If the FIFO is full, in_ready=0 for that channel, so only the pop occurs; in_ready rises the following cycle. No write-through when full.
- Push to channel 0 and pop from channel 1 (or the reverse) in the same cycle are independent.
- Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0. Occupancy is log2(DEPTH)+1 bits, range 0..DEPTH.
- Ordering: beats within one channel leave in acceptance order. There is no ordering guarantee across channels.
- Counters: yK_cnt increments by 1 on each output consume on channel K and wraps from 2^CNT_W-1 to 0. Input accepts do not affect the counters.
- Stalls: in_valid=1 with in_ready=0 accepts nothing. A source may change in_sel while stalled; in_ready follows the new in_sel in the same cycle.

Test Plan:
- Reset, then in_valid=0 -> in_ready=1, both valids 0, both data outputs 0x00, both counters 0.
- Send 0xA5 with sel=0, then 0x3C with sel=1, y0_ready=y1_ready=1 -> y0 shows 0xA5 and y1 shows 0x3C, each one cycle after its accept; y0_cnt=1, y1_cnt=1.
- y0_ready=0; push 0x11, 0x22, 0x33 to sel=0 (DEPTH=2) -> 0x11 and 0x22 are accepted, then in_ready=0 while sel=0. Switch sel=1 and push 0x44 -> accepted. Release y0_ready -> channel 0 delivers 0x11 then 0x22; 0x33 is accepted the cycle after the first pop.
- FIFO at occupancy 1, push and pop on channel 1 in the same cycle (0x55 in, 0x66 out) -> occupancy stays 1 and 0x55 is the next head.
- Deliver 256 beats on channel 0 with CNT_W=8 -> y0_cnt wraps to 0x00 and y1_cnt is unchanged.
- Assert rst_n=0 asynchronously with both FIFOs holding data -> valids drop immediately without a clock edge, and counters and data outputs read 0.
